csi_tx_packet_gen: RTL and testbench

CSI-2 link-layer packet transmitter. It is the transmit-side counterpart of the CSI-2 receiver chain. It accepts packet commands (frame start, frame end, line) plus a 32-bit payload word stream on the word clock. It emits per-lane HS bytes with a lane-enable, sync byte, ECC-protected header, payload, CRC-16 and trail bytes, for a D-PHY serializer/SB_IO DDR output stage downstream.

---
 rtl/csi_pkg.sv | 27 ++
 rtl/csi_crc16.sv | 28 ++
 rtl/csi_tx_packet_gen.sv | 128 ++++++++++++
 tb/tb_csi_tx_packet_gen.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/csi_pkg.sv
// Shared definitions for the CSI-2 link layer: FSM states, protocol constants,
// and the header ECC function.
`timescale 1ns/1ps
package csi_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_PREP, S_SYNC, S_HDR, S_DATA, S_CRC, S_TRAIL, S_GAP
  } state_t;

  localparam logic [7:0]  SYNC_BYTE   = 8'hB8;
  localparam logic [15:0] CRC_POLY    = 16'h8408;
  localparam logic [15:0] CRC_INIT    = 16'hFFFF;
  localparam logic [5:0]  DT_LONG_MIN = 6'h10;

  // 6-bit Hamming over {wc, DI}; d[0] is DI bit 0. Upper two ECC bits are zero.
  function automatic logic [7:0] csi_ecc6(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
    p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
    p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
    p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
    return {2'b00, p};
  endfunction

endpackage

// File: rtl/csi_crc16.sv
// CSI-2 payload CRC-16, reflected, LANES bytes per cycle; byte 0 (low bits) first.
`timescale 1ns/1ps
module csi_crc16 import csi_pkg::*; #(
  parameter int LANES = 2
) (
  input  logic               clock,
  input  logic               areset_n,
  input  logic               clear,
  input  logic               enable,
  input  logic [8*LANES-1:0] data,
  output logic [15:0]        crc
);

  logic [15:0] nxt;

  always_comb begin
    nxt = crc;
    for (int i = 0; i < 8*LANES; i++)
      nxt = (nxt >> 1) ^ ((nxt[0] ^ data[i]) ? CRC_POLY : 16'h0000);
  end

  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n)   crc <= CRC_INIT;
    else if (clear)  crc <= CRC_INIT;
    else if (enable) crc <= nxt;
  end

endmodule

// File: rtl/csi_tx_packet_gen.sv
// CSI-2 packet transmitter: command + word stream in, per-lane HS bytes out.
// Outputs are decoded only from flops, so no input reaches an output combinationally.
`timescale 1ns/1ps
module csi_tx_packet_gen import csi_pkg::*; #(
  parameter int         LANES  = 2,
  parameter logic [1:0] VC     = 2'b00,
  parameter int         T_PREP = 4,
  parameter int         T_GAP  = 8
) (
  input  logic               clock,
  input  logic               areset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [5:0]         cmd_dt,
  input  logic [15:0]        cmd_wc,
  input  logic               data_valid,
  output logic               data_ready,
  input  logic [31:0]        data,
  output logic               hs_en,
  output logic [8*LANES-1:0] hs_data,
  output logic               underrun
);

  localparam int          HDR_CYC = 4 / LANES;
  localparam int          CRC_CYC = 2 / LANES;
  localparam logic [15:0] WMASK   = 16'(4 / LANES - 1);

  state_t                  state, nstate;
  logic [15:0]             cnt, ncnt;
  logic [5:0]              dt_q;
  logic [15:0]             wc_q;
  logic                    live_q;
  logic [31:0]             word_q;
  logic [LANES-1:0][7:0]   last_q, lane_b;
  logic [15:0]             crc;
  logic                    is_long;
  logic [15:0]             data_cyc;
  logic [31:0]             hdr_w;

  assign is_long  = dt_q >= DT_LONG_MIN;
  assign data_cyc = (LANES == 2) ? {1'b0, wc_q[15:1]} : wc_q;
  assign hdr_w    = {csi_ecc6({wc_q, VC, dt_q}), wc_q, VC, dt_q};
  assign hs_data  = lane_b;

  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= nstate;
      cnt   <= ncnt;
    end
  end

  always_comb begin
    nstate = state;
    ncnt   = cnt + 16'd1;
    unique case (state)
      S_IDLE: begin
        ncnt = '0;
        if (cmd_valid && cmd_ready) nstate = S_PREP;
      end
      S_PREP:  if (cnt == 16'(T_PREP - 1)) begin nstate = S_SYNC; ncnt = '0; end
      S_SYNC:  begin nstate = S_HDR; ncnt = '0; end
      S_HDR:   if (cnt == 16'(HDR_CYC - 1)) begin
        ncnt   = '0;
        nstate = !is_long ? S_TRAIL : (wc_q == '0) ? S_CRC : S_DATA;
      end
      S_DATA:  if (cnt == data_cyc - 16'd1) begin nstate = S_CRC; ncnt = '0; end
      S_CRC:   if (cnt == 16'(CRC_CYC - 1)) begin nstate = S_TRAIL; ncnt = '0; end
      S_TRAIL: begin nstate = S_GAP; ncnt = '0; end
      S_GAP:   if (cnt == 16'(T_GAP - 1)) begin nstate = S_IDLE; ncnt = '0; end
      default: begin nstate = S_IDLE; ncnt = '0; end
    endcase
  end

  always_comb begin
    cmd_ready = live_q && (state == S_IDLE);
    hs_en     = (state != S_IDLE) && (state != S_GAP);
    // Ready is raised the cycle before a word's first byte cycle, so the word
    // is captured on the edge that starts it.
    data_ready = (state == S_HDR && cnt == 16'(HDR_CYC - 1) && is_long && wc_q != '0) ||
                 (state == S_DATA && (cnt & WMASK) == WMASK && cnt != data_cyc - 16'd1);
    lane_b = '0;
    for (int k = 0; k < LANES; k++) begin
      unique case (state)
        S_SYNC:  lane_b[k] = SYNC_BYTE;
        S_HDR:   lane_b[k] = 8'(hdr_w >> (8 * (int'(cnt) * LANES + k)));
        S_DATA:  lane_b[k] = 8'(word_q >> (8 * (int'(cnt & WMASK) * LANES + k)));
        S_CRC:   lane_b[k] = 8'(crc >> (8 * (int'(cnt) * LANES + k)));
        S_TRAIL: lane_b[k] = {8{~last_q[k][7]}};
        default: lane_b[k] = '0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      live_q   <= 1'b0;
      dt_q     <= '0;
      wc_q     <= '0;
      word_q   <= '0;
      last_q   <= '0;
      underrun <= 1'b0;
    end else begin
      live_q <= 1'b1;
      if (cmd_valid && cmd_ready) begin
        dt_q <= cmd_dt;
        wc_q <= (cmd_dt >= DT_LONG_MIN) ? {cmd_wc[15:2], 2'b00} : cmd_wc;
      end
      if (data_ready) begin
        word_q <= data_valid ? data : '0;
        if (!data_valid) underrun <= 1'b1;
      end
      if (hs_en && state != S_TRAIL) last_q <= lane_b;
    end
  end

  csi_crc16 #(.LANES(LANES)) u_crc (
    .clock    (clock),
    .areset_n (areset_n),
    .clear    (state == S_IDLE),
    .enable   (state == S_DATA),
    .data     (lane_b),
    .crc      (crc)
  );

endmodule

// File: tb/tb_csi_tx_packet_gen.sv
// Directed bench: FS/FE short packets, long packets, wc=0, underrun, reset mid-packet.
`timescale 1ns/1ps
module tb_csi_tx_packet_gen;

  logic gclk = 1'b0;
  always #5 gclk = ~gclk;

  logic        areset_n;
  logic        cmd_valid, cmd_ready, data_valid, data_ready, hs_en, underrun;
  logic [5:0]  cmd_dt;
  logic [15:0] cmd_wc;
  logic [31:0] data;
  logic [15:0] hs_data;

  logic        cmd_valid1, cmd_ready1, data_valid1, data_ready1, hs_en1, underrun1;
  logic [5:0]  cmd_dt1;
  logic [15:0] cmd_wc1;
  logic [31:0] data1;
  logic [7:0]  hs_data1;

  csi_tx_packet_gen #(.LANES(2), .VC(2'b00), .T_PREP(4), .T_GAP(8)) u_dut2 (
    .clock(gclk), .areset_n(areset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dt(cmd_dt), .cmd_wc(cmd_wc), .data_valid(data_valid), .data_ready(data_ready),
    .data(data), .hs_en(hs_en), .hs_data(hs_data), .underrun(underrun));

  csi_tx_packet_gen #(.LANES(1), .VC(2'b00), .T_PREP(4), .T_GAP(8)) u_dut1 (
    .clock(gclk), .areset_n(areset_n), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
    .cmd_dt(cmd_dt1), .cmd_wc(cmd_wc1), .data_valid(data_valid1), .data_ready(data_ready1),
    .data(data1), .hs_en(hs_en1), .hs_data(hs_data1), .underrun(underrun1));

  int          n_chk = 0, n_pass = 0;
  logic [15:0] cap[$];
  int          rdy_idx[$];
  int          gap_len;
  logic [15:0] gap_or;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [15:0] crc16(input logic [63:0] b, input int n);
    logic [15:0] c = 16'hFFFF;
    logic        fb;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < 8; j++) begin
        fb = c[0] ^ b[8*i+j];
        c  = c >> 1;
        if (fb) c = c ^ 16'h8408;
      end
    return c;
  endfunction

  task automatic check_seq(input string tag, input logic [15:0] e[$]);
    chk({tag, " len"}, cap.size(), e.size());
    for (int i = 0; i < e.size() && i < cap.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), cap[i], e[i]);
  endtask

  // Called at a negedge; returns at the negedge where cmd_ready is back.
  task automatic run_pkt(input logic [5:0] dt, input logic [15:0] wc,
                         input logic [31:0] w0, input logic [31:0] w1, input int drop);
    int t, wi;
    cap.delete(); rdy_idx.delete(); gap_len = 0; gap_or = '0; wi = 0;
    cmd_dt = dt; cmd_wc = wc; cmd_valid = 1'b1;
    t = 0;
    while (!cmd_ready && t < 50) begin @(negedge gclk); t++; end
    chk("accept", cmd_ready, 1);
    @(negedge gclk);
    cmd_valid = 1'b0;
    t = 0;
    while (hs_en && t < 200) begin
      cap.push_back(hs_data);
      data_valid = 1'b0;
      if (data_ready) begin
        rdy_idx.push_back(cap.size() - 1);
        data       = (wi == 0) ? w0 : w1;
        data_valid = (wi != drop);
        wi++;
      end
      @(negedge gclk);
      t++;
    end
    data_valid = 1'b0;
    chk("hs bounded", t < 200, 1);
    t = 0;
    while (!cmd_ready && t < 50) begin
      gap_len++; gap_or = gap_or | hs_data;
      @(negedge gclk); t++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] e[$];
    logic [15:0] c;
    int          t;

    areset_n = 1'b0;
    cmd_valid = 0; cmd_dt = '0; cmd_wc = '0; data_valid = 0; data = '0;
    cmd_valid1 = 0; cmd_dt1 = 6'h01; cmd_wc1 = '0; data_valid1 = 0; data1 = '0;
    repeat (2) @(negedge gclk);
    chk("rst cmd_ready", cmd_ready, 0);
    chk("rst hs_en", hs_en, 0);
    chk("rst hs_data", hs_data, 0);
    chk("rst data_ready", data_ready, 0);
    chk("rst underrun", underrun, 0);
    areset_n = 1'b1;
    @(negedge gclk);
    chk("post-rst cmd_ready", cmd_ready, 1);

    // Frame start, short
    run_pkt(6'h00, 16'h0000, '0, '0, -1);
    e = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hB8B8, 16'h0000, 16'h0000, 16'hFFFF};
    check_seq("fs", e);
    chk("fs gap", gap_len, 8);
    chk("fs gap zero", gap_or, 0);
    chk("fs no ready", rdy_idx.size(), 0);

    // Frame end on the single-lane instance
    cap.delete();
    cmd_valid1 = 1'b1;
    t = 0;
    while (!cmd_ready1 && t < 50) begin @(negedge gclk); t++; end
    @(negedge gclk);
    cmd_valid1 = 1'b0;
    t = 0;
    while (hs_en1 && t < 200) begin cap.push_back({8'h00, hs_data1}); @(negedge gclk); t++; end
    e = '{16'h00, 16'h00, 16'h00, 16'h00, 16'hB8, 16'h01, 16'h00, 16'h00, 16'h07, 16'hFF};
    check_seq("fe1", e);

    // Long packet, two words
    run_pkt(6'h2A, 16'd8, 32'h03020100, 32'h07060504, -1);
    c = crc16({32'h07060504, 32'h03020100}, 8);
    e = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hB8B8, 16'h082A, 16'h3500,
          16'h0100, 16'h0302, 16'h0504, 16'h0706, c, {{8{~c[15]}}, {8{~c[7]}}}};
    check_seq("long", e);
    chk("long ready count", rdy_idx.size(), 2);
    if (rdy_idx.size() == 2) chk("long ready spacing", rdy_idx[1] - rdy_idx[0], 2);
    chk("long underrun", underrun, 0);

    // Long packet, wc truncated from 3 to 0
    run_pkt(6'h2A, 16'd3, '0, '0, -1);
    e = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hB8B8, 16'h002A, 16'h1000,
          16'hFFFF, 16'h0000};
    check_seq("wc0", e);
    chk("wc0 no ready", rdy_idx.size(), 0);

    // Second word missing
    run_pkt(6'h2A, 16'd8, 32'h03020100, 32'hDEADBEEF, 1);
    c = crc16({32'h00000000, 32'h03020100}, 8);
    e = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hB8B8, 16'h082A, 16'h3500,
          16'h0100, 16'h0302, 16'h0000, 16'h0000, c, {{8{~c[15]}}, {8{~c[7]}}}};
    check_seq("urun", e);
    chk("urun flag", underrun, 1);

    // Reset during DATA
    cmd_dt = 6'h2A; cmd_wc = 16'd8; cmd_valid = 1'b1;
    t = 0;
    while (!cmd_ready && t < 50) begin @(negedge gclk); t++; end
    @(negedge gclk);
    cmd_valid = 1'b0; data_valid = 1'b1; data = 32'hA5A5A5A5;
    repeat (7) @(negedge gclk);
    chk("mid hs_en", hs_en, 1);
    chk("mid hs_data", hs_data, 16'hA5A5);
    #1 areset_n = 1'b0;
    #1;
    chk("arst hs_en", hs_en, 0);
    chk("arst hs_data", hs_data, 0);
    chk("arst cmd_ready", cmd_ready, 0);
    chk("arst underrun", underrun, 0);
    @(negedge gclk);
    areset_n = 1'b1; data_valid = 1'b0;
    @(negedge gclk);
    chk("re cmd_ready", cmd_ready, 1);
    run_pkt(6'h00, 16'h0000, '0, '0, -1);
    e = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hB8B8, 16'h0000, 16'h0000, 16'hFFFF};
    check_seq("after rst", e);
    chk("after rst gap", gap_len, 8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
